// File: rtl/sram_controller_if.sv
// Pipeline-side request bus for sram_controller.
// The MEM stage acts as master; the controller acts as slave.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// sram_controller: 32-bit load/store performed on a 16-bit async SRAM as LO then HI half-word phases.
// Optional macro SRAM_ADDR_CHECK_EN adds addr_err and rejects misaligned or out-of-range requests.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR    = 32'd1024,
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_controller_if.slave     bus,
  inout  wire  [15:0]          SRAM_DQ,
  output logic [17:0]          SRAM_ADDR,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_WE_N
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic                 addr_err
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WADR_W = 17;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_wr_q, is_wr_d;
  logic [WADR_W-1:0]   addr_w_q, addr_w_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         read_data_q, read_data_d;
  logic [17:0]         sram_addr_q, sram_addr_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [15:0]         dq_out_q, dq_out_d;
  logic                req_c;
  logic                last_c;
  logic                phase_c;
`ifdef SRAM_ADDR_CHECK_EN
  logic                addr_err_q, addr_err_d;
  logic                bad_addr_c;
`endif

  assign req_c  = bus.wr_en | bus.rd_en;
  assign last_c = (cnt_q == CNT_W'(PHASE_CYCLES - 1));

`ifdef SRAM_ADDR_CHECK_EN
  assign bad_addr_c = (bus.address < BASE_ADDR) || (bus.address[1:0] != 2'b00) ||
                      (((bus.address - BASE_ADDR) >> 2) > 32'h0001_FFFF);
`endif

  // Next state, request capture, and SRAM pin values aligned to the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    addr_w_d    = addr_w_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
`ifdef SRAM_ADDR_CHECK_EN
    addr_err_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req_c) begin
          is_wr_d  = bus.wr_en;
          addr_w_d = WADR_W'((bus.address - BASE_ADDR) >> 2);
          wdata_d  = bus.write_data;
          cnt_d    = '0;
          state_d  = LO;
`ifdef SRAM_ADDR_CHECK_EN
          if (bad_addr_c) begin
            state_d    = DONE;
            addr_err_d = 1'b1;
          end
`endif
        end
      end
      LO: begin
        if (last_c) begin
          if (!is_wr_q) read_data_d = {read_data_q[31:16], SRAM_DQ};
          state_d = HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HI: begin
        if (last_c) begin
          if (!is_wr_q) read_data_d = {SRAM_DQ, read_data_q[15:0]};
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // First cycle of a store phase is address setup, so WE_N stays high there.
    phase_c  = (state_d == LO) || (state_d == HI);
    we_n_d   = !(phase_c && is_wr_d && (cnt_d != '0));
    oe_n_d   = !(phase_c && !is_wr_d);
    dq_oe_d  = phase_c && is_wr_d;
    dq_out_d = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
    if (phase_c) sram_addr_d = {addr_w_d, (state_d == HI)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      addr_w_q    <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
`ifdef SRAM_ADDR_CHECK_EN
      addr_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      addr_w_q    <= addr_w_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
`ifdef SRAM_ADDR_CHECK_EN
      addr_err_q  <= addr_err_d;
`endif
    end
  end

  // ready drops combinationally the moment a request shows up in IDLE.
  assign bus.ready     = (state_q == DONE) || ((state_q == IDLE) && !req_c);
  assign bus.read_data = read_data_q;

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
  assign addr_err  = addr_err_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with a small behavioural async SRAM.
// Define SRAM_ADDR_CHECK_EN to also exercise the rejected-address path.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n, sram_we_n;
`ifdef SRAM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:15];

  sram_controller_if bus_if ();

  sram_controller dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_OE_N (sram_oe_n),
    .SRAM_WE_N (sram_we_n)
`ifdef SRAM_ADDR_CHECK_EN
    ,
    .addr_err  (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM: drives DQ while output-enabled, captures DQ while write-enabled.
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[4'(sram_addr)] : 16'bz;
  always @(negedge clk) if (!sram_we_n) mem[4'(sram_addr)] <= sram_dq;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds the request until ready, counting low cycles and strobes seen while frozen.
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, output int low, output int we_lows,
                        output int oe_lows, output logic [31:0] rdata);
    bus_if.wr_en      = wr;
    bus_if.rd_en      = rd;
    bus_if.address    = addr;
    bus_if.write_data = data;
    low = 0; we_lows = 0; oe_lows = 0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.ready) break;
      low++;
      if (!sram_we_n) we_lows++;
      if (!sram_oe_n) oe_lows++;
      tick();
    end
    check("ready_returned", 32'(bus_if.ready), 32'd1);
    rdata = bus_if.read_data;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    tick();
  endtask

  int          low, we_lows, oe_lows;
  logic [31:0] rdata;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    rst = 1'b1;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    bus_if.address = '0;
    bus_if.write_data = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_ready",     32'(bus_if.ready), 32'd1);
    check("rst_read_data", bus_if.read_data,  32'h0);
    check("rst_we_n",      32'(sram_we_n),    32'd1);
    check("rst_oe_n",      32'(sram_oe_n),    32'd1);
    check("rst_sram_addr", 32'(sram_addr),    32'h0);
    check("rst_ce_ub_lb",  32'({sram_ce_n, sram_ub_n, sram_lb_n}), 32'h0);

    // 1: store 0xDEADBEEF @1024
    access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, low, we_lows, oe_lows, rdata);
    check("t1_low_cycles", 32'(low),     32'd5);
    check("t1_we_lows",    32'(we_lows), 32'd2);
    check("t1_oe_lows",    32'(oe_lows), 32'd0);
    check("t1_mem0",       32'(mem[0]),  32'h0000_BEEF);
    check("t1_mem1",       32'(mem[1]),  32'h0000_DEAD);

    // 2: load @1024
    access(1'b0, 1'b1, 32'd1024, 32'h0, low, we_lows, oe_lows, rdata);
    check("t2_read_data",  rdata,        32'hDEAD_BEEF);
    check("t2_low_cycles", 32'(low),     32'd5);
    check("t2_oe_lows",    32'(oe_lows), 32'd4);
    check("t2_we_lows",    32'(we_lows), 32'd0);

    // 3: store/load @1028, earlier word intact
    access(1'b1, 1'b0, 32'd1028, 32'h1234_5678, low, we_lows, oe_lows, rdata);
    check("t3_mem2", 32'(mem[2]), 32'h0000_5678);
    check("t3_mem3", 32'(mem[3]), 32'h0000_1234);
    access(1'b0, 1'b1, 32'd1028, 32'h0, low, we_lows, oe_lows, rdata);
    check("t3_read_1028", rdata, 32'h1234_5678);
    access(1'b0, 1'b1, 32'd1024, 32'h0, low, we_lows, oe_lows, rdata);
    check("t3_read_1024", rdata, 32'hDEAD_BEEF);

    // 4: both enables high is a store
    access(1'b1, 1'b1, 32'd1032, 32'hA5A5_5A5A, low, we_lows, oe_lows, rdata);
    check("t4_oe_lows",    32'(oe_lows), 32'd0);
    check("t4_we_lows",    32'(we_lows), 32'd2);
    check("t4_mem4",       32'(mem[4]),  32'h0000_5A5A);
    check("t4_mem5",       32'(mem[5]),  32'h0000_A5A5);
    check("t4_read_held",  rdata,        32'hDEAD_BEEF);

    // 5: reset during HI of a store
    bus_if.wr_en = 1'b1;
    bus_if.address = 32'd1036;
    bus_if.write_data = 32'h1111_2222;
    tick();
    tick();
    tick();
    tick();
    check("t5_in_hi_addr", 32'(sram_addr), 32'd7);
    check("t5_in_hi_we_n", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    bus_if.wr_en = 1'b0;
    tick();
    rst = 1'b0;
    check("t5_ready",     32'(bus_if.ready), 32'd1);
    check("t5_we_n",      32'(sram_we_n),    32'd1);
    check("t5_oe_n",      32'(sram_oe_n),    32'd1);
    check("t5_read_data", bus_if.read_data,  32'h0);
    check("t5_sram_addr", 32'(sram_addr),    32'h0);

`ifdef SRAM_ADDR_CHECK_EN
    // 6: misaligned load is rejected without an SRAM cycle
    tick();
    bus_if.rd_en = 1'b1;
    bus_if.address = 32'd1026;
    #1;
    check("t6_ready_low", 32'(bus_if.ready), 32'd0);
    check("t6_err_idle",  32'(addr_err),     32'd0);
    tick();
    check("t6_ready_done", 32'(bus_if.ready), 32'd1);
    check("t6_err_done",   32'(addr_err),     32'd1);
    check("t6_oe_n",       32'(sram_oe_n),    32'd1);
    check("t6_read_data",  bus_if.read_data,  32'h0);
    bus_if.rd_en = 1'b0;
    tick();
    check("t6_err_cleared", 32'(addr_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
